// File: rtl/irq_ack_sequencer_if.sv
// Handshake bundle between the interrupt acknowledge sequencer, the vectored
// interrupt controller (irq/irqv/inta) and the host side that drains vectors.
interface irq_ack_sequencer_if;
    logic        en;
    logic        irq;
    logic [7:0]  irqv;
    logic        inta;
    logic        busy;
    logic [7:0]  vec_out;
    logic        vec_valid;
    logic        vec_rd;
    logic        fifo_full;
    logic [15:0] ack_cnt;

    // Sequencer side
    modport slave (
        input  en, irq, irqv, vec_rd,
        output inta, busy, vec_out, vec_valid, fifo_full, ack_cnt
    );

    // Controller / host side
    modport master (
        output en, irq, irqv, vec_rd,
        input  inta, busy, vec_out, vec_valid, fifo_full, ack_cnt
    );
endinterface

// File: rtl/irq_ack_sequencer.sv
// CPU-side interrupt acknowledge sequencer: confirms irq, drives a fixed-length
// active-low inta pulse, captures the vector just before release, holds off
// while the controller's inta sync pipeline settles, and queues vectors in a
// small first-word-fall-through FIFO. All state updates on the falling edge.
module irq_ack_sequencer #(
    parameter int INTA_LEN = 17,
    parameter int HOLDOFF  = 8,
    parameter int FIFO_AW  = 2
) (
    input  logic sclk,
    input  logic rst,
    irq_ack_sequencer_if.slave bus
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int CNT_MX = (INTA_LEN > HOLDOFF) ? INTA_LEN : HOLDOFF;
    localparam int CNT_W  = $clog2(CNT_MX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONF = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t               state_r, state_nx_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
    logic                 inta_r, inta_nx_s;
    logic                 busy_r;
    logic                 push_s, pop_s;
    logic [15:0]          ack_cnt_r;

    logic [7:0]           mem_r [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_r, wr_ptr_nx_s;
    logic [FIFO_AW-1:0]   rd_ptr_r, rd_ptr_nx_s;
    logic [FIFO_AW:0]     occ_r, occ_nx_s;
    logic [7:0]           vec_out_r, head_nx_s;
    logic                 vec_valid_r, fifo_full_r;

    // Next-state, acknowledge counter and inta level for the acknowledge FSM
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        inta_nx_s  = 1'b1;
        push_s     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (bus.en && bus.irq && !fifo_full_r) begin
                    state_nx_s = CONF;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CONF: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (bus.irq) begin
                    state_nx_s = ACK;
                    inta_nx_s  = 1'b0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ACK: begin
                if (cnt_r == CNT_W'(INTA_LEN - 1)) begin
                    state_nx_s = HOLD;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    inta_nx_s  = 1'b1;
                    push_s     = 1'b1;
                end else begin
                    cnt_nx_s  = cnt_r + CNT_W'(1);
                    inta_nx_s = 1'b0;
                end
            end
            HOLD: begin
                if (cnt_r == CNT_W'(HOLDOFF - 1)) begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Next FIFO pointers, occupancy and the head value after this edge
    always_comb begin
        pop_s       = bus.vec_rd && (occ_r != {(FIFO_AW+1){1'b0}});
        wr_ptr_nx_s = wr_ptr_r;
        rd_ptr_nx_s = rd_ptr_r;
        occ_nx_s    = occ_r;
        if (push_s) begin
            wr_ptr_nx_s = wr_ptr_r + FIFO_AW'(1);
        end else begin
            wr_ptr_nx_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nx_s = rd_ptr_r + FIFO_AW'(1);
        end else begin
            rd_ptr_nx_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   occ_nx_s = occ_r + (FIFO_AW+1)'(1);
            2'b01:   occ_nx_s = occ_r - (FIFO_AW+1)'(1);
            default: occ_nx_s = occ_r;
        endcase
        // A push lands in the head slot when the FIFO was empty or drains to it
        if (occ_nx_s == {(FIFO_AW+1){1'b0}}) begin
            head_nx_s = 8'h00;
        end else if (push_s && (rd_ptr_nx_s == wr_ptr_r)) begin
            head_nx_s = bus.irqv;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FSM state, counters and all registered outputs
    always_ff @(negedge sclk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            inta_r      <= 1'b1;
            busy_r      <= 1'b0;
            ack_cnt_r   <= 16'h0000;
            wr_ptr_r    <= {FIFO_AW{1'b0}};
            rd_ptr_r    <= {FIFO_AW{1'b0}};
            occ_r       <= {(FIFO_AW+1){1'b0}};
            vec_out_r   <= 8'h00;
            vec_valid_r <= 1'b0;
            fifo_full_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            inta_r      <= inta_nx_s;
            busy_r      <= (state_nx_s != IDLE);
            if (push_s) begin
                ack_cnt_r <= ack_cnt_r + 16'h0001;
            end else begin
                ack_cnt_r <= ack_cnt_r;
            end
            wr_ptr_r    <= wr_ptr_nx_s;
            rd_ptr_r    <= rd_ptr_nx_s;
            occ_r       <= occ_nx_s;
            vec_out_r   <= head_nx_s;
            vec_valid_r <= (occ_nx_s != {(FIFO_AW+1){1'b0}});
            fifo_full_r <= (occ_nx_s == (FIFO_AW+1)'(DEPTH));
        end
    end

    // Vector storage; contents are only meaningful where occupancy says so
    always_ff @(negedge sclk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= bus.irqv;
        end
    end

    assign bus.inta      = inta_r;
    assign bus.busy      = busy_r;
    assign bus.ack_cnt   = ack_cnt_r;
    assign bus.vec_out   = vec_out_r;
    assign bus.vec_valid = vec_valid_r;
    assign bus.fifo_full = fifo_full_r;
endmodule
